// File: rtl/mem_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_rd_arbiter
// Description : Round-robin arbiter sharing one AXI read master between
//               NUM_REQ read requesters. A grant is held for a whole
//               transfer. The arbiter drives the master's control port and
//               steers the master's output stream to the granted requester.
// Ports       : aclk/areset          - clock, synchronous active-high reset
//               req_valid/addr/size  - level requests, flattened per requester
//               req_done             - one-cycle completion pulse per requester
//               m_axis_*             - per-requester stream (shared tdata)
//               ctrl_*               - read master control port
//               s_axis_*             - read master output stream
//               busy, grant_id       - status
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rd_arbiter #(
    parameter int NUM_REQ            = 2,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_AXIS_TDATA_WIDTH = 512
) (
    input  logic                                            aclk,
    input  logic                                            areset,
    input  logic [NUM_REQ-1:0]                              req_valid,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]           req_addr,
    input  logic [NUM_REQ*C_XFER_SIZE_WIDTH-1:0]            req_size,
    output logic [NUM_REQ-1:0]                              req_done,
    output logic [NUM_REQ-1:0]                              m_axis_tvalid,
    input  logic [NUM_REQ-1:0]                              m_axis_tready,
    output logic [NUM_REQ-1:0]                              m_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0]                   m_axis_tdata,
    output logic                                            ctrl_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]                   ctrl_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]                    ctrl_xfer_size_in_bytes,
    input  logic                                            ctrl_done,
    input  logic                                            s_axis_tvalid,
    output logic                                            s_axis_tready,
    input  logic                                            s_axis_tlast,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]                   s_axis_tdata,
    output logic                                            busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id
);

    localparam int c_GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_AW       = C_M_AXI_ADDR_WIDTH;
    localparam int c_XW       = C_XFER_SIZE_WIDTH;
    // One extra bit so the beat count of the largest size cannot overflow.
    localparam int c_CW       = C_XFER_SIZE_WIDTH + 1;
    localparam int c_BYTES    = C_AXIS_TDATA_WIDTH / 8;
    localparam int c_LG_BYTES = $clog2(c_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_GW-1:0]   r_grant;
    logic [c_GW-1:0]   r_rr_ptr;
    logic [c_CW-1:0]   r_exp_beats;
    logic [c_CW-1:0]   r_beat_cnt;
    logic              r_done_seen;

    logic              w_any;
    logic              w_hi_found;
    logic [c_GW-1:0]   w_hi_pick;
    logic [c_GW-1:0]   w_lo_pick;
    logic [c_GW-1:0]   w_pick;
    logic [c_AW-1:0]   w_pick_addr;
    logic [c_XW-1:0]   w_pick_size;
    logic [c_CW-1:0]   w_pick_beats;
    logic              w_grant_rdy;
    logic              w_room;
    logic              w_beat;
    logic [c_CW-1:0]   w_cnt_nxt;
    logic              w_xfer_done;
    logic [c_GW-1:0]   w_ptr_nxt;

    // Round-robin pick: the first set request at or above the pointer wins;
    // otherwise the lowest set request below it (wrap-around). Descending
    // loops leave the lowest qualifying index as the last assignment.
    always_comb begin
        w_any      = |req_valid;
        w_hi_found = 1'b0;
        w_hi_pick  = '0;
        w_lo_pick  = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                if (c_GW'(j) >= r_rr_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_pick  = c_GW'(j);
                end else begin
                    w_lo_pick  = c_GW'(j);
                end
            end
        end
        w_pick = w_hi_found ? w_hi_pick : w_lo_pick;
    end

    // Per-requester selects written as compare loops so every index is static.
    always_comb begin
        w_pick_addr = '0;
        w_pick_size = '0;
        w_grant_rdy = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_pick == c_GW'(j)) begin
                w_pick_addr = req_addr[j*c_AW +: c_AW];
                w_pick_size = req_size[j*c_XW +: c_XW];
            end
            if (r_grant == c_GW'(j)) begin
                w_grant_rdy = m_axis_tready[j];
            end
        end
    end

    assign w_pick_beats = ({1'b0, w_pick_size} + c_CW'(c_BYTES - 1)) >> c_LG_BYTES;

    // Stream steering: purely combinational so beats pass without latency.
    // Beats past the expected count are refused.
    assign w_room        = (r_state == S_BUSY) && (r_beat_cnt < r_exp_beats);
    assign s_axis_tready = w_room & w_grant_rdy;
    assign w_beat        = s_axis_tvalid & s_axis_tready;
    assign m_axis_tdata  = s_axis_tdata;

    always_comb begin
        m_axis_tvalid = '0;
        m_axis_tlast  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_room && (r_grant == c_GW'(j))) begin
                m_axis_tvalid[j] = s_axis_tvalid;
                m_axis_tlast[j]  = s_axis_tvalid & s_axis_tlast;
            end
        end
    end

    // Completion needs both the master's done and a fully drained stream;
    // the master may report done while beats are still queued in its FIFO.
    assign w_cnt_nxt   = r_beat_cnt + c_CW'(w_beat);
    assign w_xfer_done = (r_done_seen | ctrl_done) && (w_cnt_nxt == r_exp_beats);
    assign w_ptr_nxt   = (r_grant == c_GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ctrl_start  = 1'b0;
        req_done    = '0;
        busy        = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = (w_pick_size == '0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                ctrl_start  = 1'b1;
                w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (w_xfer_done) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    req_done[j] = (r_grant == c_GW'(j));
                end
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_grant                 <= '0;
            r_rr_ptr                <= '0;
            r_exp_beats             <= '0;
            r_beat_cnt              <= '0;
            r_done_seen             <= 1'b0;
            ctrl_addr_offset        <= '0;
            ctrl_xfer_size_in_bytes <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant                 <= w_pick;
                        ctrl_addr_offset        <= w_pick_addr;
                        ctrl_xfer_size_in_bytes <= w_pick_size;
                        r_exp_beats             <= w_pick_beats;
                    end
                end
                S_START: begin
                    r_beat_cnt  <= '0;
                    r_done_seen <= 1'b0;
                end
                S_BUSY: begin
                    r_beat_cnt <= w_cnt_nxt;
                    if (ctrl_done) begin
                        r_done_seen <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_rr_ptr <= w_ptr_nxt;
                end
                default: ;
            endcase
        end
    end

    assign grant_id = r_grant;

endmodule
`default_nettype wire
